// File: rtl/rv_pipe_buf.sv
// Elastic valid/ready pipeline buffer: a DEPTH-entry circular queue whose control
// field is cleared by reset/flush and whose data field is never reset.
module rv_pipe_buf #(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 2,
  parameter int PASS_READY = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              i_pr_clk,
  input  logic              i_pr_rst,
  input  logic              i_pr_flush,
  input  logic              i_pr_valid,
  output logic              o_pr_ready,
  input  logic [CTRL_W-1:0] i_pr_ctrl,
  input  logic [DATA_W-1:0] i_pr_data,
  output logic              o_pr_valid,
  input  logic              i_pr_ready,
  output logic [CTRL_W-1:0] o_pr_ctrl,
  output logic [DATA_W-1:0] o_pr_data,
  output logic [CNT_W-1:0]  o_pr_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("rv_pipe_buf: DEPTH must be >= 1");
  end

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              not_full;
  logic              push;
  logic              pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_full   = (count_reg < FULL);
  assign o_pr_valid = (count_reg != '0);
  assign o_pr_ready = !i_pr_rst && !i_pr_flush &&
                      (not_full || ((PASS_READY != 0) && i_pr_ready));
  assign push       = i_pr_valid && o_pr_ready;
  assign pop        = o_pr_valid && i_pr_ready;
  assign o_pr_ctrl  = o_pr_valid ? ctrl_mem[rd_ptr_reg] : '0;
  assign o_pr_data  = data_mem[rd_ptr_reg];
  assign o_pr_count = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_pr_clk or posedge i_pr_rst) begin
    if (i_pr_rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else if (i_pr_flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic              wen;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;

    assign wen = push && (wr_ptr_reg == PTR_W'(gi));

    always_ff @(posedge i_pr_clk or posedge i_pr_rst) begin
      if (i_pr_rst) begin
        ctrl_reg <= '0;
      end else if (i_pr_flush) begin
        ctrl_reg <= '0;
      end else if (wen) begin
        ctrl_reg <= i_pr_ctrl;
      end
    end

    // Payload has no reset so it can map onto plain storage.
    always_ff @(posedge i_pr_clk) begin
      if (wen) data_reg <= i_pr_data;
    end

    assign ctrl_mem[gi] = ctrl_reg;
    assign data_mem[gi] = data_reg;
  end

  always_ff @(posedge i_pr_clk) begin
    if (!i_pr_rst) begin
      assert (count_reg <= FULL) else $error("rv_pipe_buf: count above DEPTH");
      assert (!(pop && (count_reg == '0))) else $error("rv_pipe_buf: pop while empty");
      assert (!(push && !pop && (count_reg == FULL))) else $error("rv_pipe_buf: push while full");
    end
  end

endmodule
